// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and I2C write-engine signals shared by the command arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the engine.
interface i2c_cmd_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [24*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      err;
  logic                 busy;
  logic [31:0]          i2c_data;
  logic                 i2c_go;
  logic                 i2c_end;
  logic                 i2c_ack;

  modport master (
    output req, req_data, i2c_end, i2c_ack,
    input  grant, done, err, busy, i2c_data, i2c_go
  );

  modport slave (
    input  req, req_data, i2c_end, i2c_ack,
    output grant, done, err, busy, i2c_data, i2c_go
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C write engine among NREQ register-write requesters,
// with NACK retry, per-phase timeout and per-requester done/error pulses.
module i2c_cmd_arbiter #(
  parameter int          NREQ       = 4,
  parameter logic [7:0]  SLAVE_ADDR = 8'hBA,
  parameter int          MAX_RETRY  = 3,
  parameter logic [19:0] TIMEOUT    = 20'd600000
) (
  input logic              clk,
  input logic              rst,
  i2c_cmd_arbiter_if.slave bus
);

  localparam int             IW       = $clog2(NREQ);
  localparam logic [IW-1:0]  LAST_RST = IW'(NREQ - 1);
  localparam logic [2:0]     MAX_R    = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, WAIT_END, GAP, OK, FAIL
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   last, last_n, pick;
  logic            found;
  int              idx;
  logic [23:0]     cmd, cmd_n;
  logic [2:0]      retry, retry_n;
  logic [19:0]     timer, timer_n, timer_inc;
  logic [1:0]      gap_cnt, gap_n;
  logic [NREQ-1:0] grant_r, grant_n, done_r, done_n, err_r, err_n;
  logic            busy_r, busy_n, go_r, go_n;
  logic [31:0]     data_r, data_n;

  // Descending scan so the last hit is the nearest index after LAST.
  always_comb begin
    found = 1'b0;
    pick  = last;
    idx   = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NREQ;
      if (bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_n   = state;
    last_n    = last;
    cmd_n     = cmd;
    retry_n   = retry;
    timer_n   = timer;
    gap_n     = gap_cnt;
    grant_n   = '0;
    done_n    = '0;
    err_n     = '0;
    busy_n    = busy_r;
    go_n      = go_r;
    data_n    = data_r;
    timer_inc = (timer == '1) ? timer : timer + 20'd1;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (found) begin
          grant_n[pick] = 1'b1;
          cmd_n         = bus.req_data[24*pick +: 24];
          last_n        = pick;
          busy_n        = 1'b1;
          state_n       = ISSUE;
        end
      end
      ISSUE: begin
        data_n  = {SLAVE_ADDR, cmd};
        go_n    = 1'b1;
        timer_n = '0;
        state_n = WAIT_START;
      end
      WAIT_START: begin
        timer_n = timer_inc;
        if (!bus.i2c_end) begin
          state_n = WAIT_END;
        end else if (timer_inc == TIMEOUT) begin
          go_n    = 1'b0;
          state_n = FAIL;
        end
      end
      WAIT_END: begin
        timer_n = timer_inc;
        if (bus.i2c_end) begin
          go_n = 1'b0;
          if (!bus.i2c_ack) begin
            state_n = OK;
          end else if (retry < MAX_R) begin
            retry_n = retry + 3'd1;
            gap_n   = '0;
            state_n = GAP;
          end else begin
            state_n = FAIL;
          end
        end else if (timer_inc == TIMEOUT) begin
          go_n    = 1'b0;
          state_n = FAIL;
        end
      end
      GAP: begin
        gap_n = gap_cnt + 2'd1;
        if (gap_cnt == 2'd3) state_n = ISSUE;
      end
      OK: begin
        done_n[last] = 1'b1;
        retry_n      = '0;
        state_n      = IDLE;
      end
      FAIL: begin
        err_n[last] = 1'b1;
        retry_n     = '0;
        go_n        = 1'b0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= LAST_RST;
      retry   <= '0;
      timer   <= '0;
      gap_cnt <= '0;
      grant_r <= '0;
      done_r  <= '0;
      err_r   <= '0;
      busy_r  <= 1'b0;
      go_r    <= 1'b0;
      data_r  <= '0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      retry   <= retry_n;
      timer   <= timer_n;
      gap_cnt <= gap_n;
      grant_r <= grant_n;
      done_r  <= done_n;
      err_r   <= err_n;
      busy_r  <= busy_n;
      go_r    <= go_n;
      data_r  <= data_n;
    end
  end

  // Captured command is pure data; it is only read after a grant reloads it.
  always_ff @(posedge clk) begin
    cmd <= cmd_n;
  end

  assign bus.grant    = grant_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.busy     = busy_r;
  assign bus.i2c_go   = go_r;
  assign bus.i2c_data = data_r;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: behavioural I2C engine, event monitors and
// a linear sequence of hand-computed checks.
module tb_i2c_cmd_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  i2c_cmd_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_cmd_arbiter #(
    .NREQ(NREQ), .SLAVE_ADDR(8'hBA), .MAX_RETRY(3), .TIMEOUT(20'd100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Engine model: starts on GO with END high, holds END low eng_low cycles, then reports ACK.
  int   eng_low         = 10;
  int   eng_nack_until  = 0;
  bit   eng_always_nack = 1'b0;
  bit   eng_stuck       = 1'b0;
  int   eng_cnt         = 0;
  int   eng_done_n      = 0;
  logic eng_end         = 1'b1;
  logic eng_ack         = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      eng_cnt = 0;
      eng_end = 1'b1;
      eng_ack = 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_end = 1'b1;
        eng_ack = eng_always_nack || (eng_done_n < eng_nack_until);
        eng_done_n++;
      end
    end else if (bus.i2c_go && eng_end && !eng_stuck) begin
      eng_end = 1'b0;
      eng_cnt = eng_low;
    end
  end

  assign bus.i2c_end = eng_end;
  assign bus.i2c_ack = eng_ack;

  // Event monitors
  int          go_rise_n   = 0;
  int          go_low_run  = 0;
  logic        go_prev     = 1'b0;
  logic [31:0] go_data_log [0:63];
  int          gap_log     [0:63];
  int          done_cnt    [0:NREQ-1];
  int          err_cnt     [0:NREQ-1];
  int          done_total  = 0;
  int          err_total   = 0;
  int          grant_total = 0;
  int          grant_bad   = 0;

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      done_cnt[k] = 0;
      err_cnt[k]  = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.i2c_go && !go_prev) begin
      go_data_log[go_rise_n % 64] = bus.i2c_data;
      gap_log[go_rise_n % 64]     = go_low_run;
      go_rise_n++;
    end
    if (bus.i2c_go) go_low_run = 0;
    else            go_low_run++;
    go_prev = bus.i2c_go;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.done[k]) begin done_cnt[k]++; done_total++; end
      if (bus.err[k])  begin err_cnt[k]++;  err_total++;  end
    end
    if (bus.grant != '0) begin
      grant_total++;
      if (!$onehot(bus.grant)) grant_bad++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        for (int k = 0; k < NREQ; k++) if (bus.grant[k]) idx = k;
        break;
      end
    end
  endtask

  task automatic wait_end(input int bound, output logic [3:0] d, output logic [3:0] e,
                          output int busy_low);
    d = '0;
    e = '0;
    busy_low = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if ((bus.done | bus.err) != '0) begin
        d = bus.done;
        e = bus.err;
        break;
      end
      if (bus.busy !== 1'b1) busy_low++;
    end
  endtask

  initial begin
    int         idx;
    int         bl;
    int         hc;
    int         s_go, s_done, s_err, s_gr, s_e3;
    logic [3:0] d, e;
    int         got    [0:5];
    int         exp_rr [0:5];
    exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 2;
    exp_rr[3] = 3; exp_rr[4] = 0; exp_rr[5] = 1;

    bus.req      = '0;
    bus.req_data = {24'h330003, 24'h220002, 24'h090438, 24'h110001};
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'(4'b0000));
    chk("rst_done",  32'(bus.done),  32'(4'b0000));
    chk("rst_err",   32'(bus.err),   32'(4'b0000));
    chk("rst_busy",  32'(bus.busy),  32'(1'b0));
    chk("rst_go",    32'(bus.i2c_go), 32'(1'b0));
    chk("rst_data",  bus.i2c_data,   32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single write from requester 1
    s_go = go_rise_n; s_done = done_total; s_err = err_total; s_gr = grant_total;
    bus.req = 4'b0010;
    wait_grant(idx);
    chk("t1_grant_idx", 32'(idx), 32'(1));
    chk("t1_grant_vec", 32'(bus.grant), 32'(4'b0010));
    chk("t1_busy_grant", 32'(bus.busy), 32'(1'b1));
    chk("t1_go_issue", 32'(bus.i2c_go), 32'(1'b0));
    bus.req = '0;
    @(negedge clk);
    chk("t1_go_high", 32'(bus.i2c_go), 32'(1'b1));
    chk("t1_data", bus.i2c_data, 32'hBA090438);
    wait_end(40, d, e, bl);
    chk("t1_done", 32'(d), 32'(4'b0010));
    chk("t1_err", 32'(e), 32'(4'b0000));
    chk("t1_busy_low_cycles", 32'(bl), 32'(0));
    chk("t1_busy_at_done", 32'(bus.busy), 32'(1'b1));
    @(negedge clk);
    chk("t1_busy_after", 32'(bus.busy), 32'(1'b0));
    chk("t1_go_pulses", 32'(go_rise_n - s_go), 32'(1));
    chk("t1_done_count", 32'(done_total - s_done), 32'(1));
    chk("t1_err_count", 32'(err_total - s_err), 32'(0));
    chk("t1_grant_count", 32'(grant_total - s_gr), 32'(1));

    // Round-robin with all four requesting from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eng_low = 2;
    bus.req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      wait_grant(idx);
      got[t] = idx;
      if (idx >= 0) bus.req[idx] = 1'b0;
      wait_end(40, d, e, bl);
      if (t < 5 && idx >= 0) bus.req[idx] = 1'b1;
      else                   bus.req = '0;
    end
    for (int t = 0; t < 6; t++) chk($sformatf("t2_order%0d", t), 32'(got[t]), 32'(exp_rr[t]));
    s_gr = grant_total;
    repeat (5) @(negedge clk);
    chk("t2_withdraw_no_grant", 32'(grant_total - s_gr), 32'(0));
    chk("t2_grant_onehot", 32'(grant_bad), 32'(0));

    // Two NACKs, then ACK
    eng_low = 3;
    eng_nack_until = eng_done_n + 2;
    s_go = go_rise_n; s_err = err_total;
    bus.req = 4'b0100;
    wait_grant(idx);
    chk("t3_grant_idx", 32'(idx), 32'(2));
    bus.req = '0;
    wait_end(200, d, e, bl);
    chk("t3_done", 32'(d), 32'(4'b0100));
    chk("t3_err", 32'(e), 32'(4'b0000));
    chk("t3_go_pulses", 32'(go_rise_n - s_go), 32'(3));
    for (int r = 0; r < 3; r++)
      chk($sformatf("t3_data%0d", r), go_data_log[(s_go + r) % 64], 32'hBA220002);
    chk("t3_gap1_ge4", 32'(gap_log[(s_go + 1) % 64] >= 4), 32'(1'b1));
    chk("t3_gap2_ge4", 32'(gap_log[(s_go + 2) % 64] >= 4), 32'(1'b1));
    chk("t3_err_count", 32'(err_total - s_err), 32'(0));

    // Retry exhaustion for requester 3, requester 0 pending
    eng_always_nack = 1'b1;
    s_go = go_rise_n; s_e3 = err_cnt[3];
    bus.req = 4'b1001;
    wait_grant(idx);
    chk("t4_grant_idx", 32'(idx), 32'(3));
    bus.req = 4'b0001;
    wait_end(300, d, e, bl);
    eng_always_nack = 1'b0;
    chk("t4_err", 32'(e), 32'(4'b1000));
    chk("t4_done", 32'(d), 32'(4'b0000));
    chk("t4_go_pulses", 32'(go_rise_n - s_go), 32'(4));
    wait_grant(idx);
    chk("t4_next_grant", 32'(idx), 32'(0));
    chk("t4_err_pulses", 32'(err_cnt[3] - s_e3), 32'(1));
    bus.req = '0;
    wait_end(60, d, e, bl);
    chk("t4_next_done", 32'(d), 32'(4'b0001));

    // Timeout in WAIT_START
    eng_stuck = 1'b1;
    bus.req = 4'b0001;
    wait_grant(idx);
    chk("t5_grant_idx", 32'(idx), 32'(0));
    bus.req = '0;
    hc = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.i2c_go) hc++;
      else            break;
    end
    chk("t5_go_high_cycles", 32'(hc), 32'(100));
    wait_end(10, d, e, bl);
    chk("t5_err", 32'(e), 32'(4'b0001));
    chk("t5_done", 32'(d), 32'(4'b0000));
    @(negedge clk);
    chk("t5_busy_after", 32'(bus.busy), 32'(1'b0));
    eng_stuck = 1'b0;

    // Reset during WAIT_END
    eng_low = 10;
    bus.req = 4'b0100;
    wait_grant(idx);
    chk("t6_grant_idx", 32'(idx), 32'(2));
    bus.req = '0;
    repeat (4) @(negedge clk);
    chk("t6_go_mid", 32'(bus.i2c_go), 32'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk("t6_grant", 32'(bus.grant), 32'(4'b0000));
    chk("t6_done",  32'(bus.done),  32'(4'b0000));
    chk("t6_err",   32'(bus.err),   32'(4'b0000));
    chk("t6_busy",  32'(bus.busy),  32'(1'b0));
    chk("t6_go",    32'(bus.i2c_go), 32'(1'b0));
    chk("t6_data",  bus.i2c_data,   32'h0);
    rst = 1'b0;
    s_done = done_total; s_err = err_total;
    repeat (15) @(negedge clk);
    chk("t6_no_done", 32'(done_total - s_done), 32'(0));
    chk("t6_no_err", 32'(err_total - s_err), 32'(0));
    bus.req = 4'b1010;
    wait_grant(idx);
    chk("t6_grant_after_rst", 32'(idx), 32'(1));
    bus.req = 4'b1000;
    wait_end(60, d, e, bl);
    chk("t6_done1", 32'(d), 32'(4'b0010));
    wait_grant(idx);
    chk("t6_grant_next", 32'(idx), 32'(3));
    bus.req = '0;
    wait_end(60, d, e, bl);
    chk("t6_done3", 32'(d), 32'(4'b1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Shares one I2C write engine (32-bit word {slave, sub-address, data16}, GO/END/ACK handshake) among up to NREQ independent register-write requesters, such as exposure adjust, zoom-window reload and gain tuning. Arbitration is round-robin. Each granted command is framed with the fixed slave address and issued to the engine. The block retries on NACK, bounds every transfer with a timeout, and returns a per-requester done or error pulse. It sits between the sensor-configuration sources and the I2C controller, in the iCLK domain.

## Interface
- NREQ, 4: number of requesters (2..8).
- SLAVE_ADDR, 8'hBA: write address placed in oI2C_DATA[31:24].
- MAX_RETRY, 3: NACK retries after the first attempt (0..7).
- TIMEOUT, 20'd600000: iCLK cycles allowed per engine phase before abort.
- iCLK  in  1  system clock.
- iRST  in  1  reset; synchronous, active-high.
- iREQ  in  NREQ  per-requester level request; held until oGRANT bit seen.
- iREQ_DATA  in  24*NREQ  command for requester k at [24k+23:24k], {sub_addr8, data16}.
- oGRANT  out  NREQ  one-hot 1-cycle pulse; command captured this cycle.
- oDONE  out  NREQ  1-cycle pulse: write ACKed.
- oERR  out  NREQ  1-cycle pulse: retries exhausted or timeout.
- oBUSY  out  1  high from grant until done/err pulse inclusive.
- oI2C_DATA  out  32  {SLAVE_ADDR, captured 24-bit command}.
- oI2C_GO  out  1  start request to engine.
- iI2C_END  in  1  engine end flag, already synchronized to iCLK; high when idle, low during transfer.
- iI2C_ACK  in  1  sampled when END rises; 1 = NACK/failure, 0 = success.

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer LAST = NREQ-1; retry count 0; timer 0.
- States:
  - **IDLE**: if any iREQ, select the first set bit searching LAST+1, LAST+2, … modulo NREQ. In the same cycle: pulse oGRANT, capture data into CMD, set LAST = winner, set oBUSY, go to ISSUE.
  - **ISSUE**: drive oI2C_DATA = {SLAVE_ADDR, CMD} and oI2C_GO = 1; clear timer; go to WAIT_START.
  - **WAIT_START**: hold GO. When iI2C_END = 0, go to WAIT_END. If the timer reaches TIMEOUT, go to FAIL.
  - **WAIT_END**: hold GO. When iI2C_END = 1, drop GO and sample iI2C_ACK. ACK = 0 goes to OK. ACK = 1 with retry < MAX_RETRY increments retry and goes to GAP. Otherwise go to FAIL. If the timer reaches TIMEOUT, go to FAIL.
  - **GAP**: GO = 0 for 4 iCLK cycles, then go to ISSUE with the same CMD.
  - **OK**: pulse oDONE[winner]; clear retry; go to IDLE.
  - **FAIL**: pulse oERR[winner]; GO = 0; clear retry; go to IDLE.
- oBUSY drops in the cycle after the done/err pulse.
- The timer is 20 bits, counts each cycle in WAIT_*, and saturates.
- oI2C_DATA is stable from ISSUE until the next grant.
- Requests that arrive while busy are not lost. They wait, level-held, and are arbitrated on return to IDLE.
- Deasserting iREQ before grant withdraws the request with no side effects.
- A requester that re-requests immediately after its own done pulse yields to any other pending requester, because LAST points at it.
- iRST in any state, including mid-transfer, returns to reset values in the next cycle. GO falls immediately and no done/err pulse is emitted.

## Timing
- Grant latency: 1 cycle from iREQ high in IDLE (grant on the first edge that samples iREQ).
- GO rises 1 cycle after grant.
- Done/err pulse fires 1 cycle after the END rising edge is sampled.
- Minimum grant-to-grant spacing, zero-retry transfer: grant, ISSUE, ≥1 WAIT_START, ≥1 WAIT_END, OK, IDLE/grant, which is 5 cycles plus engine time.
- The gap between transfers is ≥1 cycle with GO low, so the engine always sees a GO falling edge.
- All outputs are registered.

## Test plan
- Single write: NREQ=4, iREQ=4'b0010, data 24'h090438. Engine model holds END low 10 cycles, then ACK=0. Required: oGRANT=4'b0010 once, oI2C_DATA=32'hBA090438, one oDONE[1] pulse, no oERR, oBUSY high throughout.
- Round-robin fairness: iREQ=4'b1111 held, requesters re-assert after each done. Required: grant order 0,1,2,3,0,1. No requester is granted twice before all others are served.
- NACK retry: engine returns ACK=1 twice, then 0. Required: exactly 3 GO pulses with identical oI2C_DATA, ≥4 GO-low cycles between them, then oDONE; no oERR.
- Retry exhaustion: ACK=1 always, MAX_RETRY=3. Required: 4 GO pulses, then a single oERR pulse for the granted requester; the next pending request is granted afterward.
- Timeout: END never falls, TIMEOUT=100. Required: GO drops and oERR pulses at cycle 100 of WAIT_START; the arbiter returns to IDLE.
- Reset mid-transfer: assert iRST during WAIT_END for 1 cycle. Required: the next cycle shows all outputs 0, no done/err pulse, LAST=NREQ-1 (the next grant goes to the lowest pending index).
